mux_rr_reg: RTL and testbench

MUX_RR_REG -- requirements
Module: mux_rr_reg

---
 rtl/mux_rr_reg.sv | 90 +++++++++
 tb/tb_mux_rr_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// Registered N:1 channel multiplexer with manual select or round-robin scan.
// Valid/ready on every input channel and on the single registered output.
module mux_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               xfer_count
);

    logic [WIDTH-1:0] lanes [CHANNELS];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] cand;
    logic             grant_ok;
    logic             sel_ok;
    logic             load_en;
    logic             take;
    logic             give;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign lanes[k] = din[k*WIDTH +: WIDTH];
    end

    assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
    assign load_en = !out_valid || out_ready;
    assign give    = out_valid && out_ready;

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        cand     = '0;
        if (mode) begin
            for (int i = 1; i <= CHANNELS; i++) begin
                cand = SEL_W'((int'(ptr) + i) % CHANNELS);
                if (!grant_ok && in_valid[cand]) begin
                    grant    = cand;
                    grant_ok = 1'b1;
                end
            end
        end else begin
            grant    = sel;
            grant_ok = sel_ok;
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && grant_ok) begin
            in_ready[grant] = load_en;
        end
    end

    assign take = !rst && grant_ok && load_en && in_valid[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            out_chan   <= '0;
            out_valid  <= 1'b0;
            ptr        <= SEL_W'(CHANNELS - 1);
            xfer_count <= '0;
        end else begin
            if (take) begin
                dout      <= lanes[grant];
                out_chan  <= grant;
                out_valid <= 1'b1;
                ptr       <= grant;
            end else if (give) begin
                out_valid <= 1'b0;
            end
            if (give) begin
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg with a scoreboard queue of expected words.
module tb_mux_rr_reg;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  dout;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_count;

    logic [23:0] b_din;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_sel;
    logic [7:0]  b_dout;
    logic [1:0]  b_out_chan;
    logic        b_out_valid;
    logic [15:0] b_xfer_count;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    bit   chk    = 1;
    logic [15:0] xsave;

    mux_rr_reg #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .dout(dout),
        .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    mux_rr_reg #(.WIDTH(8), .CHANNELS(3)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(1'b0), .sel(b_sel), .dout(b_dout),
        .out_chan(b_out_chan), .out_valid(b_out_valid),
        .out_ready(1'b1), .xfer_count(b_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] chdata(input int k);
        logic [31:0] d;
        d = 32'hDDCCBBAA;
        return d[k*8 +: 8];
    endfunction

    task automatic push(input int k);
        exp_t e;
        e.chan = 2'(k);
        e.data = chdata(k);
        sb.push_back(e);
    endtask

    // One clock: retire the word taken at this edge, then compare the new head.
    task automatic tick();
        logic taken;
        taken = out_valid && out_ready;
        @(posedge clk);
        #1;
        if (taken && sb.size() > 0) void'(sb.pop_front());
        if (chk && out_valid) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                check("dout", 32'(dout), 32'(sb[0].data));
                check("out_chan", 32'(out_chan), 32'(sb[0].chan));
            end
        end
    endtask

    initial begin
        rst = 1'b0; din = 32'hDDCCBBAA; in_valid = 4'b1111; mode = 1'b1;
        sel = 2'd0; out_ready = 1'b1;
        b_din = 24'hCCBBAA; b_in_valid = 3'b111; b_sel = 2'd0;
        #1 rst = 1'b1;
        #11;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_chan", 32'(out_chan), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_xfer", 32'(xfer_count), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        mode = 1'b0;

        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #0 check("man_ready", 32'(in_ready), 32'(1 << s));
            push(s);
            tick();
        end
        in_valid = 4'b0000;
        tick();
        check("man_drain", 32'(out_valid), 32'h0);
        check("man_xfer", 32'(xfer_count), 32'd4);

        mode = 1'b1;
        in_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #0 check("rr_ready", 32'(in_ready), 32'(1 << (n % 4)));
            push(n % 4);
            tick();
            check("rr_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 4'b0000;
        tick();
        check("rr_drain", 32'(out_valid), 32'h0);

        #2 rst = 1'b1;
        #2 rst = 1'b0;
        in_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            #0 check("sp_ready", 32'(in_ready), 32'((n % 2) ? 4'b1000 : 4'b0010));
            push((n % 2) ? 3 : 1);
            tick();
        end
        in_valid = 4'b0000;
        tick();
        check("sp_xfer", 32'(xfer_count), 32'd4);

        mode = 1'b0; sel = 2'd1; in_valid = 4'b1111;
        push(1);
        tick();
        out_ready = 1'b0;
        sel = 2'd2;
        xsave = xfer_count;
        for (int n = 0; n < 3; n++) begin
            #0 check("bp_ready", 32'(in_ready), 32'h0);
            tick();
        end
        check("bp_xfer", 32'(xfer_count), 32'(xsave));
        out_ready = 1'b1;
        #0 check("bp_release", 32'(in_ready), 32'b0100);
        push(2);
        tick();
        in_valid = 4'b0000;
        tick();
        check("bp_drain", 32'(out_valid), 32'h0);
        check("sb_left", 32'(sb.size()), 32'd0);

        check("b_valid", 32'(b_out_valid), 32'h1);
        check("b_dout", 32'(b_dout), 32'hAA);
        b_sel = 2'd3;
        #0 check("b_ready", 32'(b_in_ready), 32'h0);
        tick();
        check("b_drain", 32'(b_out_valid), 32'h0);
        tick();
        check("b_idle", 32'(b_out_valid), 32'h0);

        sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b0;
        push(0);
        tick();
        check("hold_valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_xfer", 32'(xfer_count), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h0);
        sb.delete();
        #1 rst = 1'b0;

        chk = 0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1 check("wrap_max", 32'(xfer_count), 32'hFFFF);
        @(posedge clk);
        #1 check("wrap_zero", 32'(xfer_count), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
